// File: rtl/gradient_pkg.sv
// Shared types and constants for the gradient magnitude/direction stage.
package gradient_pkg;

  // Quantized gradient direction consumed by non-maximum suppression.
  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

  // tan(22.5) ~= 106/256 and tan(67.5) ~= 618/256.
  localparam int unsigned TAN22_NUM     = 106;
  localparam int unsigned TAN67_NUM     = 618;
  localparam int unsigned TAN_DEN_SHIFT = 8;

  // Output word layout: magnitude at bit 0, direction directly above it.
  localparam int unsigned OUT_WIDTH     = 16;
  localparam int unsigned MAG_LSB       = 0;
  localparam int unsigned DIR_WIDTH     = 2;
  localparam int unsigned MAG_WIDTH_MAX = 14;

  // Packs magnitude and direction; the direction sits at bit mag_width.
  // The caller guarantees mag < 2**mag_width, so the fields never overlap.
  function automatic logic [OUT_WIDTH-1:0] pack_tdata(
    input logic [MAG_WIDTH_MAX-1:0] mag,
    input dir_e                     dir,
    input int unsigned              mag_width
  );
    logic [OUT_WIDTH-1:0] mag_f;
    logic [OUT_WIDTH-1:0] dir_f;
    mag_f = {{(OUT_WIDTH-MAG_WIDTH_MAX){1'b0}}, mag} << MAG_LSB;
    dir_f = {{(OUT_WIDTH-DIR_WIDTH){1'b0}}, dir} << mag_width;
    return mag_f | dir_f;
  endfunction

endpackage

// File: rtl/grad_dir_quantizer.sv
// Combinational gradient direction quantizer. It works on the pre-scaled
// magnitudes (256*ay, 106*ax, 618*ax) so that the multiplies can live in an
// earlier pipeline stage; only comparators remain here.
module grad_dir_quantizer
  import gradient_pkg::*;
#(
  parameter int unsigned PROD_W = 27
) (
  input  logic [PROD_W-1:0] ay_scaled_i,   // 256 * |Gy|
  input  logic [PROD_W-1:0] ax_tan22_i,    // 106 * |Gx|
  input  logic [PROD_W-1:0] ax_tan67_i,    // 618 * |Gx|
  input  logic              sign_eq_i,     // sign(Gx) == sign(Gy), zero positive
  output dir_e              dir_o
);

  // Sector selection: near-horizontal wins ties (covers Gx=Gy=0), then
  // near-vertical, then the diagonal picked by the sign relationship.
  always_comb begin
    dir_o = DIR_0;
    if (ay_scaled_i <= ax_tan22_i) begin
      dir_o = DIR_0;
    end else if (ay_scaled_i >= ax_tan67_i) begin
      dir_o = DIR_90;
    end else if (sign_eq_i) begin
      dir_o = DIR_45;
    end else begin
      dir_o = DIR_135;
    end
  end

endmodule

// File: rtl/gradient_mag_dir.sv
// Streaming L1 gradient magnitude and quantized direction, three register
// stages at one pixel per clock with full backpressure.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Valid never depends on ready. The whole pipeline
// shares one enable (en = !m_axis_tvalid || m_axis_tready); s_axis_tready is
// that enable, so a stalled output freezes every stage and holds m_axis_*.
module gradient_mag_dir
  import gradient_pkg::*;
#(
  parameter int unsigned GRAD_WIDTH = 16,
  parameter int unsigned MAG_WIDTH  = 8,    // at most MAG_WIDTH_MAX
  parameter int unsigned MAG_SHIFT  = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [2*GRAD_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int unsigned ABS_W  = GRAD_WIDTH + 1;   // |-2^(W-1)| fits exactly
  localparam int unsigned SUM_W  = GRAD_WIDTH + 2;
  localparam int unsigned PROD_W = GRAD_WIDTH + 11;  // 618 * |G| headroom
  localparam logic [SUM_W-1:0] MAG_MAX = SUM_W'((2 ** MAG_WIDTH) - 1);

  // Global stage enable.
  logic en;

  // Stage 1: absolute values, sign relation, sideband.
  logic [GRAD_WIDTH-1:0] gx, gy;
  logic [ABS_W-1:0]      ax_d, ay_d;
  logic                  sign_eq_d;
  logic                  v1_q;
  logic [ABS_W-1:0]      ax_q, ay_q;
  logic                  sign_eq1_q, user1_q, last1_q;

  // Stage 2: sum and scaled products.
  logic [SUM_W-1:0]      sum_d;
  logic [PROD_W-1:0]     ay_scaled_d, ax_tan22_d, ax_tan67_d;
  logic                  v2_q;
  logic [SUM_W-1:0]      sum_q;
  logic [PROD_W-1:0]     ay_scaled_q, ax_tan22_q, ax_tan67_q;
  logic                  sign_eq2_q, user2_q, last2_q;

  // Stage 3: saturation, direction, output registers.
  logic [SUM_W-1:0]         mag_shifted;
  logic [SUM_W-1:0]         mag_sat;
  dir_e                     dir;
  logic [OUT_WIDTH-1:0]     tdata_d;
  logic                     m_valid_q;
  logic [OUT_WIDTH-1:0]     m_tdata_q;
  logic                     m_user_q, m_last_q;

  assign en            = !m_valid_q || m_axis_tready;
  assign s_axis_tready = en;

  assign gx = s_axis_tdata[GRAD_WIDTH-1:0];
  assign gy = s_axis_tdata[2*GRAD_WIDTH-1:GRAD_WIDTH];

  // Two's-complement absolute value, widened one bit so the most negative
  // input maps to its exact positive magnitude.
  always_comb begin
    ax_d      = gx[GRAD_WIDTH-1] ? (~{1'b1, gx}) + ABS_W'(1) : {1'b0, gx};
    ay_d      = gy[GRAD_WIDTH-1] ? (~{1'b1, gy}) + ABS_W'(1) : {1'b0, gy};
    sign_eq_d = (gx[GRAD_WIDTH-1] == gy[GRAD_WIDTH-1]);
  end

  // Stage 1 registers; data only loads with a real beat so bubbles carry no sideband.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1_q       <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      sign_eq1_q <= 1'b0;
      user1_q    <= 1'b0;
      last1_q    <= 1'b0;
    end else if (en) begin
      v1_q <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        ax_q       <= ax_d;
        ay_q       <= ay_d;
        sign_eq1_q <= sign_eq_d;
        user1_q    <= s_axis_tuser;
        last1_q    <= s_axis_tlast;
      end
    end
  end

  // L1 sum plus the three products the direction comparators need.
  always_comb begin
    sum_d       = SUM_W'(ax_q) + SUM_W'(ay_q);
    ay_scaled_d = PROD_W'(ay_q) << TAN_DEN_SHIFT;
    ax_tan22_d  = PROD_W'(ax_q) * PROD_W'(TAN22_NUM);
    ax_tan67_d  = PROD_W'(ax_q) * PROD_W'(TAN67_NUM);
  end

  // Stage 2 registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v2_q        <= 1'b0;
      sum_q       <= '0;
      ay_scaled_q <= '0;
      ax_tan22_q  <= '0;
      ax_tan67_q  <= '0;
      sign_eq2_q  <= 1'b0;
      user2_q     <= 1'b0;
      last2_q     <= 1'b0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum_q       <= sum_d;
        ay_scaled_q <= ay_scaled_d;
        ax_tan22_q  <= ax_tan22_d;
        ax_tan67_q  <= ax_tan67_d;
        sign_eq2_q  <= sign_eq1_q;
        user2_q     <= user1_q;
        last2_q     <= last1_q;
      end
    end
  end

  grad_dir_quantizer #(
    .PROD_W (PROD_W)
  ) u_quant (
    .ay_scaled_i (ay_scaled_q),
    .ax_tan22_i  (ax_tan22_q),
    .ax_tan67_i  (ax_tan67_q),
    .sign_eq_i   (sign_eq2_q),
    .dir_o       (dir)
  );

  // Scale, clamp to all ones, then pack with the direction.
  always_comb begin
    mag_shifted = sum_q >> MAG_SHIFT;
    mag_sat     = (mag_shifted > MAG_MAX) ? MAG_MAX : mag_shifted;
    tdata_d     = pack_tdata(MAG_WIDTH_MAX'(mag_sat), dir, MAG_WIDTH);
  end

  // Stage 3 / output registers; held while the downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      m_valid_q <= 1'b0;
      m_tdata_q <= '0;
      m_user_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (en) begin
      m_valid_q <= v2_q;
      if (v2_q) begin
        m_tdata_q <= tdata_d;
        m_user_q  <= user2_q;
        m_last_q  <= last2_q;
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_gradient_mag_dir.sv
// Bench for gradient_mag_dir: directed vectors, a random-backpressure frame,
// and a mid-line reset, checked against an expected-beat queue.
module tb_gradient_mag_dir;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, m_tready;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_w;
  logic [17:0] held;
  bit   stalled_q = 1'b0;
  bit   rand_ready = 1'b0;
  logic fixed_ready = 1'b1;
  int   out_cnt = 0;
  int   user_cnt = 0;
  int   last_cnt = 0;

  // Clock
  always #5 clk = ~clk;

  gradient_mag_dir #(
    .GRAD_WIDTH (16),
    .MAG_WIDTH  (8),
    .MAG_SHIFT  (3)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
  );

  // Reference: L1 magnitude >> 3 clamped to 255, direction by integer compare.
  function automatic logic [15:0] model(input logic [15:0] gxr, input logic [15:0] gyr);
    int gx, gy, ax, ay, mag, dir;
    gx  = int'($signed(gxr));
    gy  = int'($signed(gyr));
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = (ax + ay) / 8;
    if (mag > 255) mag = 255;
    if (256 * ay <= 106 * ax)      dir = 0;
    else if (256 * ay >= 618 * ax) dir = 2;
    else if ((gx < 0) == (gy < 0)) dir = 1;
    else                           dir = 3;
    return 16'(dir * 256 + mag);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready driver
  initial m_tready = 1'b1;
  always @(posedge clk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Scoreboard: push on input handshake, pop on output handshake, stall hold.
  always @(negedge clk) begin
    if (rst) begin
      stalled_q = 1'b0;
    end else begin
      if (stalled_q && m_tvalid)
        chk("stall_hold", {14'b0, m_tuser, m_tlast, m_tdata}, {14'b0, held});
      if (s_tvalid && s_tready)
        exp_q.push_back({s_tuser, s_tlast, model(s_tdata[15:0], s_tdata[31:16])});
      if (m_tvalid && m_tready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed=%0h expected=none", m_tdata);
        end
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          chk("beat", {14'b0, m_tuser, m_tlast, m_tdata}, {14'b0, exp_w});
        end
        out_cnt++;
        if (m_tuser) user_cnt++;
        if (m_tlast) last_cnt++;
      end
      stalled_q = m_tvalid && !m_tready;
      held      = {m_tuser, m_tlast, m_tdata};
    end
  end

  // Driver: present one beat and hold it until accepted.
  task automatic send(input logic [15:0] gx, input logic [15:0] gy,
                      input logic user, input logic last);
    bit acc;
    int n;
    s_tdata  = {gy, gx};
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // One isolated beat with ready high: checks 3-edge latency and value.
  task automatic single(input string tag, input logic [15:0] gx,
                        input logic [15:0] gy, input logic [15:0] exp_d);
    send(gx, gy, 1'b0, 1'b0);
    chk({tag, "_lat1"}, 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(m_tvalid), 32'd1);
    chk(tag, 32'(m_tdata), 32'(exp_d));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  function automatic logic [15:0] rand_grad();
    logic [15:0] ext[3];
    ext[0] = 16'h8000;
    ext[1] = 16'h7FFF;
    ext[2] = 16'h0000;
    case ($urandom_range(0, 2))
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(0, 600)) - 16'd300;
      default: return ext[$urandom_range(0, 2)];
    endcase
  endfunction

  task automatic frame(input int w, input int h);
    out_cnt  = 0;
    user_cnt = 0;
    last_cnt = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        send(rand_grad(), rand_grad(), (x == 0 && y == 0), (x == w - 1));
      end
    end
    drain();
    chk("frame_count", out_cnt, w * h);
    chk("frame_tuser", user_cnt, 32'd1);
    chk("frame_tlast", last_cnt, h);
  endtask

  initial begin
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);

    // Directed vectors
    single("gx100_gy0",     16'd100,  16'd0,          16'h000C);
    single("gx0_gym50",     16'd0,    -16'sd50,       16'h0206);
    single("gx40_gy40",     16'd40,   16'd40,         16'h010A);
    single("gx40_gym40",    16'd40,   -16'sd40,       16'h030A);
    single("zero",          16'd0,    16'd0,          16'h0000);
    single("thr22_eq",      16'd256,  16'd106,        16'h002D);
    single("thr22_above",   16'd256,  16'd107,        16'h012D);
    single("thr67_eq",      16'd256,  16'd618,        16'h026D);
    single("thr67_below",   16'd256,  16'd617,        16'h016D);
    single("sat_min_min",   16'h8000, 16'h8000,       16'h01FF);
    single("mag_255_exact", 16'd2047, 16'd0,          16'h00FF);
    single("mag_256_sat",   -16'sd2048, 16'd0,        16'h00FF);
    drain();

    // Random frame with random backpressure
    rand_ready = 1'b1;
    frame(32, 8);

    // Fill the pipeline under a stall, then reset mid-line
    rand_ready  = 1'b0;
    fixed_ready = 1'b0;
    @(posedge clk); #1;
    send(16'd500, 16'd20, 1'b1, 1'b0);
    send(16'd30, -16'sd700, 1'b0, 1'b0);
    send(-16'sd90, 16'd90, 1'b0, 1'b0);
    s_tdata  = {16'd5, 16'd5};
    s_tvalid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(m_tdata), 32'd0);
    chk("mid_rst_tuser", 32'(m_tuser), 32'd0);
    chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
    chk("mid_rst_tready", 32'(s_tready), 32'd1);
    fixed_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(m_tvalid), 32'd0);
    end

    // Next frame after the reset
    rand_ready = 1'b1;
    frame(16, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
